filter_out_aligner: RTL and testbench

FILTER_OUT_ALIGNER -- requirements
Module: filter_out_aligner

---
 rtl/filter_out_aligner.sv | 175 +++++++++++++++++
 tb/tb_filter_out_aligner.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_out_aligner.sv
// filter_out_aligner: tags raw filter results with their frame position. It
// keeps the interior (valid-window) results and frames them with sop/eop.
// The results are buffered in a small first-word-fall-through FIFO for a
// downstream consumer that may stall.
// Optional build macro FILTER_BORDER_ZERO_EN: keep every beat and force the
// data of border beats to zero, giving a full-size output frame.
module filter_out_aligner #(
    parameter int unsigned FP_WORD_LENGTH = 32,
    parameter int unsigned IMAGE_WIDTH    = 640,
    parameter int unsigned IMAGE_HEIGHT   = 480,
    parameter int unsigned KERNEL_SIZE    = 3,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic [FP_WORD_LENGTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FP_WORD_LENGTH-1:0] out_data,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic                      frame_done,
    output logic                      overflow,
    input  logic                      clr_overflow
);

    localparam int unsigned COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int unsigned ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH   > 1) ? $clog2(FIFO_DEPTH)   : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_EDGE = COL_W'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_EDGE = ROW_W'(KERNEL_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic                      sop;
        logic                      eop;
        logic [FP_WORD_LENGTH-1:0] data;
    } entry_t;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] tag_col;
    logic [ROW_W-1:0] tag_row;
    logic [COL_W-1:0] col_nxt;
    logic [ROW_W-1:0] row_nxt;

    logic   interior;
    logic   chosen;
    entry_t push_entry;

    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    logic   full;
    logic   pop;
    logic   push;
    logic   drop;
    entry_t head;

    // Position tag of the current beat: a start-of-frame beat is always (0,0).
    always_comb begin
        tag_col = col;
        tag_row = row;
        if (in_sof) begin
            tag_col = '0;
            tag_row = '0;
        end
    end

    // Raster advance from the tagged position, wrapping at line and frame ends.
    always_comb begin
        col_nxt = tag_col + COL_W'(1);
        row_nxt = tag_row;
        if (tag_col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (tag_row == ROW_LAST) ? '0 : tag_row + ROW_W'(1);
        end
    end

    // Beat selection and the entry that would be pushed for it.
    always_comb begin
        interior        = (tag_col >= COL_EDGE) && (tag_row >= ROW_EDGE);
        push_entry.eop  = (tag_col == COL_LAST) && (tag_row == ROW_LAST);
`ifdef FILTER_BORDER_ZERO_EN
        chosen          = 1'b1;
        push_entry.data = interior ? in_data : '0;
        push_entry.sop  = (tag_col == '0) && (tag_row == '0);
`else
        chosen          = interior;
        push_entry.data = in_data;
        push_entry.sop  = (tag_col == COL_EDGE) && (tag_row == ROW_EDGE);
`endif
    end

    // FIFO handshake: a full FIFO still accepts a push when the head leaves.
    always_comb begin
        head      = mem[rd_ptr];
        full      = (count == CNT_FULL);
        pop       = out_valid && out_ready;
        push      = in_valid && chosen && (!full || pop);
        drop      = in_valid && chosen && full && !pop;
        count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    end

    // Head entry falls through onto the output port.
    assign out_data = head.data;
    assign out_sop  = head.sop;
    assign out_eop  = head.eop;

    // Position counters advance on every input beat, chosen or not.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            col <= col_nxt;
            row <= row_nxt;
        end
    end

    // FIFO storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // FIFO pointers, occupancy and the registered valid flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
        end
    end

    // End-of-frame pulse and sticky overflow flag; a new drop beats a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= pop && head.eop;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_filter_out_aligner.sv
// Directed bench for filter_out_aligner on an 8x6 image, 3x3 kernel, 4-deep FIFO.
// Expectations follow the FILTER_BORDER_ZERO_EN setting of the build.
module tb_filter_out_aligner;

    localparam int W = 8;
    localparam int H = 6;
    localparam int K = 3;
    localparam int D = 4;
`ifdef FILTER_BORDER_ZERO_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif
    localparam int F = ZERO_EN ? 0 : (K - 1) * W + (K - 1);

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_sof;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic        frame_done;
    logic        overflow;
    logic        clr_overflow;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t got[$];
    beat_t exp_q[$];
    int    fd_cnt;
    bit    mon_en = 1'b0;

    filter_out_aligner #(
        .FP_WORD_LENGTH(32),
        .IMAGE_WIDTH   (W),
        .IMAGE_HEIGHT  (H),
        .KERNEL_SIZE   (K),
        .FIFO_DEPTH    (D)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture popped beats and frame_done pulses away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) got.push_back({out_data, out_sop, out_eop});
            if (frame_done) fd_cnt++;
        end
    end

    function automatic bit is_interior(int idx);
        return ((idx % W) >= K - 1) && ((idx / W) >= K - 1);
    endfunction

    function automatic bit is_chosen(int idx);
        return ZERO_EN || is_interior(idx);
    endfunction

    function automatic beat_t exp_beat(int idx);
        beat_t b;
        b.data = (ZERO_EN && !is_interior(idx)) ? 32'd0 : 32'(idx);
        b.sop  = (idx == F);
        b.eop  = (idx == W * H - 1);
        return b;
    endfunction

    task automatic add_expected(int first, int last);
        for (int i = first; i <= last; i++)
            if (is_chosen(i)) exp_q.push_back(exp_beat(i));
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(int idx, bit sof);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = 32'(idx);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_range(int first, int last, bit sof_first);
        for (int i = first; i <= last; i++) send(i, sof_first && (i == first));
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        in_sof       = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
        got    = {};
        exp_q  = {};
        fd_cnt = 0;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        in_valid     = 1'b1;
        in_sof       = 1'b0;
        in_data      = 32'd5;
        out_ready    = 1'b1;
        clr_overflow = 1'b0;
        idle(3);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
        n_checks++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL rst_out_data got %0d required 0", out_data); end
        n_checks++; if (out_sop !== 1'b0) begin n_fail++; $display("FAIL rst_out_sop got %b required 0", out_sop); end
        n_checks++; if (out_eop !== 1'b0) begin n_fail++; $display("FAIL rst_out_eop got %b required 0", out_eop); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done got %b required 0", frame_done); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got %b required 0", overflow); end
        in_valid = 1'b0;
    endtask

    task automatic test_frame();
        do_reset();
        out_ready = 1'b1;
        mon_en    = 1'b1;
        send_range(0, W * H - 1, 1'b1);
        idle(8);
        mon_en = 1'b0;
        add_expected(0, W * H - 1);
        n_checks++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL frame_len got %0d required %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL frame_beat%0d got d=%0d sop=%b eop=%b required d=%0d sop=%b eop=%b",
                         i, got[i].data, got[i].sop, got[i].eop, exp_q[i].data, exp_q[i].sop, exp_q[i].eop);
            end
        end
        n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL frame_done_cnt got %0d required 1", fd_cnt); end
    endtask

    task automatic test_overflow();
        beat_t hb;
        do_reset();
        for (int i = 0; i <= F + 4; i++) begin
            if (i == F) begin
                n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_pre_valid got %b required 0", out_valid); end
            end
            send(i, i == 0);
            if (i == F) begin
                hb = exp_beat(F);
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_latency got %b required 1", out_valid); end
                n_checks++; if ({out_data, out_sop, out_eop} !== hb) begin n_fail++; $display("FAIL ovf_first_head got d=%0d sop=%b required d=%0d sop=%b", out_data, out_sop, hb.data, hb.sop); end
            end
            if (i == F + 3) begin
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_full_no_flag got %b required 0", overflow); end
            end
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b required 1", overflow); end
        idle(2);
        hb = exp_beat(F);
        n_checks++; if ({out_data, out_sop, out_eop} !== hb || out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_head_stable got d=%0d v=%b required d=%0d v=1", out_data, out_valid, hb.data); end
        clr_overflow = 1'b1;
        idle(1);
        clr_overflow = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b required 0", overflow); end
        out_ready = 1'b1;
        mon_en    = 1'b1;
        idle(6);
        mon_en = 1'b0;
        add_expected(F, F + 3);
        n_checks++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL ovf_len got %0d required %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_beat%0d got d=%0d required d=%0d", i, got[i].data, exp_q[i].data); end
        end
    endtask

    task automatic test_full_push_pop();
        beat_t hb;
        do_reset();
        send_range(0, F + 3, 1'b1);
        out_ready = 1'b1;
        send(F + 4, 1'b0);
        out_ready = 1'b0;
        hb = exp_beat(F + 1);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pp_overflow got %b required 0", overflow); end
        n_checks++; if ({out_data, out_sop, out_eop} !== hb || out_valid !== 1'b1) begin n_fail++; $display("FAIL pp_head got d=%0d v=%b required d=%0d v=1", out_data, out_valid, hb.data); end
        clr_overflow = 1'b1;
        send(F + 5, 1'b0);
        clr_overflow = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL pp_still_full_set_wins got %b required 1", overflow); end
        clr_overflow = 1'b1;
        idle(1);
        clr_overflow = 1'b0;
        out_ready = 1'b1;
        mon_en    = 1'b1;
        idle(6);
        mon_en = 1'b0;
        add_expected(F + 1, F + 4);
        n_checks++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL pp_len got %0d required %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL pp_beat%0d got d=%0d required d=%0d", i, got[i].data, exp_q[i].data); end
        end
    endtask

    task automatic test_mid_sof();
        do_reset();
        out_ready = 1'b1;
        mon_en    = 1'b1;
        send_range(0, 29, 1'b1);
        send_range(0, W * H - 1, 1'b1);
        idle(8);
        mon_en = 1'b0;
        add_expected(0, 29);
        add_expected(0, W * H - 1);
        n_checks++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL sof_len got %0d required %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL sof_beat%0d got d=%0d sop=%b eop=%b required d=%0d sop=%b eop=%b",
                         i, got[i].data, got[i].sop, got[i].eop, exp_q[i].data, exp_q[i].sop, exp_q[i].eop);
            end
        end
        n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL sof_frame_done_cnt got %0d required 1", fd_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        send_range(0, F + 2, 1'b1);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmf_queued got %b required 1", out_valid); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_valid_async got %b required 0", out_valid); end
        n_checks++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL rmf_data_async got %0d required 0", out_data); end
        idle(2);
        reset_n = 1'b1;
        idle(1);
        got    = {};
        exp_q  = {};
        fd_cnt = 0;
        out_ready = 1'b1;
        mon_en    = 1'b1;
        send_range(0, W * H - 1, 1'b0);
        idle(8);
        mon_en = 1'b0;
        add_expected(0, W * H - 1);
        n_checks++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL rmf_len got %0d required %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rmf_beat%0d got d=%0d sop=%b eop=%b required d=%0d sop=%b eop=%b",
                         i, got[i].data, got[i].sop, got[i].eop, exp_q[i].data, exp_q[i].sop, exp_q[i].eop);
            end
        end
        n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL rmf_frame_done_cnt got %0d required 1", fd_cnt); end
    endtask

    initial begin
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        in_sof       = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;
        fd_cnt       = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_frame();
        test_overflow();
        test_full_push_pop();
        test_mid_sof();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
